pc_redirect_arbiter: RTL

Sequences every PC redirect into the IF0 fetch stage. Arbitrates the four redirect sources (WB exception/ertn, EX branch resolve, ID predecode fix-up, PRIV refetch) by fixed priority. Holds the winning target while fetch is stalled and issues it as a single registered `set_pc_o` pulse with a companion flush. Tracks the post-redirect alignment cycle so IF0 re-aligns to an 8-byte fetch boundary after a redirect to an odd-word target.

---
 rtl/pc_redirect_arbiter_if.sv | 41 ++++
 rtl/pc_redirect_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/pc_redirect_arbiter_if.sv
// Purpose: bundles the redirect request, IF0 handshake and perf read-back signals of the PC redirect arbiter.
// Latency: none, this is only wiring.
// Backpressure: if0_allowin is the single backpressure input, driven by IF0 on the master side.
// Ports: req_*/pc_* are the redirect requests and targets; if0_allowin is the IF0 ready signal;
//        set_pc_o/pc_o/src_o/flush_o/align_o are the redirect outputs; perf_sel/perf_cnt_o read the counters.
interface pc_redirect_arbiter_if #(
    parameter int PC_W = 32
);
    logic            req_wb;
    logic            req_ex;
    logic            req_id;
    logic            req_priv;
    logic [PC_W-1:0] pc_wb;
    logic [PC_W-1:0] pc_ex;
    logic [PC_W-1:0] pc_id;
    logic [PC_W-1:0] pc_priv;
    logic            if0_allowin;
    logic            set_pc_o;
    logic [PC_W-1:0] pc_o;
    logic [1:0]      src_o;
    logic            flush_o;
    logic            align_o;
    logic [2:0]      perf_sel;
    logic [31:0]     perf_cnt_o;

    // Pipeline side: raises redirects, reports IF0 readiness and reads counters.
    modport master (
        output req_wb, req_ex, req_id, req_priv,
        output pc_wb, pc_ex, pc_id, pc_priv,
        output if0_allowin, perf_sel,
        input  set_pc_o, pc_o, src_o, flush_o, align_o, perf_cnt_o
    );

    // Arbiter side.
    modport slave (
        input  req_wb, req_ex, req_id, req_priv,
        input  pc_wb, pc_ex, pc_id, pc_priv,
        input  if0_allowin, perf_sel,
        output set_pc_o, pc_o, src_o, flush_o, align_o, perf_cnt_o
    );
endinterface

// File: rtl/pc_redirect_arbiter.sv
// Purpose: fixed-priority (WB > EX > ID > PRIV) arbiter that sequences PC redirects into IF0.
// Latency: a request sampled at edge N gives flush_o in cycle N+1, and set_pc_o as soon as if0_allowin=1.
// Backpressure: holds the pending target while if0_allowin=0; only an equal or higher priority request replaces it.
// Ports: clk, rstn (async active-low) and the io bundle (slave modport of pc_redirect_arbiter_if).
// Optional feature: define REDIRECT_PERF_EN to build the 32-bit performance counters; otherwise
// perf_cnt_o is tied to 0.
module pc_redirect_arbiter #(
    parameter int PC_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    pc_redirect_arbiter_if.slave  io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        ALIGN = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [1:0]      src_q;

    logic            any_req;
    logic [1:0]      win_src;
    logic [PC_W-1:0] win_pc;
    logic            take;
    logic            consume;

    // The source code doubles as the priority level, so replacement is a plain compare.
    always_comb begin
        any_req = io.req_wb | io.req_ex | io.req_id | io.req_priv;
        win_src = 2'd0;
        win_pc  = io.pc_priv;
        if (io.req_wb) begin
            win_src = 2'd3;
            win_pc  = io.pc_wb;
        end else if (io.req_ex) begin
            win_src = 2'd2;
            win_pc  = io.pc_ex;
        end else if (io.req_id) begin
            win_src = 2'd1;
            win_pc  = io.pc_id;
        end
    end

    // A stalled pending redirect can only be displaced by an equal or higher priority source;
    // once IF0 consumes it any new winner is captured unconditionally.
    assign consume = (state == PEND) & io.if0_allowin;
    assign take    = any_req & ((state != PEND) | io.if0_allowin | (win_src >= src_q));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            pc_q  <= '0;
            src_q <= 2'd0;
        end else begin
            if (take) begin
                pc_q  <= win_pc;
                src_q <= win_src;
            end
            case (state)
                IDLE: begin
                    if (any_req) state <= PEND;
                end
                PEND: begin
                    if (io.if0_allowin) begin
                        if (any_req)    state <= PEND;
                        else if (pc_q[2]) state <= ALIGN;
                        else            state <= IDLE;
                    end
                end
                ALIGN: begin
                    if (any_req)             state <= PEND;
                    else if (io.if0_allowin) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.set_pc_o = consume;
    assign io.flush_o  = (state == PEND);
    assign io.align_o  = (state == ALIGN);
    assign io.pc_o     = pc_q;
    assign io.src_o    = src_q;

`ifdef REDIRECT_PERF_EN
    // cnt[0..3]: consumed redirects per source, cnt[4]: stalled PEND cycles, cnt[5]: dropped requests.
    logic [31:0] cnt [0:5];
    logic [31:0] perf_q;
    logic [2:0]  n_req;
    logic [2:0]  n_drop;

    assign n_req  = {2'b0, io.req_wb} + {2'b0, io.req_ex} + {2'b0, io.req_id} + {2'b0, io.req_priv};
    assign n_drop = n_req - {2'b0, take};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
            perf_q <= '0;
        end else begin
            if (io.perf_sel < 3'd6) perf_q <= cnt[io.perf_sel];
            else                    perf_q <= '0;
            if (consume)                         cnt[3'(src_q)] <= cnt[3'(src_q)] + 32'd1;
            if ((state == PEND) && !io.if0_allowin) cnt[4] <= cnt[4] + 32'd1;
            cnt[5] <= cnt[5] + {29'b0, n_drop};
        end
    end

    assign io.perf_cnt_o = perf_q;
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^io.perf_sel;
    assign io.perf_cnt_o   = 32'd0;
`endif

endmodule
